pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_next_pc_calc.sv | 33 +++
 rtl/pc_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the program-counter sequencer: FSM state
// encoding, the sequential PC increment and the default fetch timeout.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ERR   = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INCR         = 32'd4;
  localparam int          TIMEOUT_DEFAULT = 15;

  // Word-align an address by clearing its two byte-select bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Next-PC selection: jump target, branch target or sequential pc+4.
// Jump has priority over branch; all sums wrap modulo 2^32 and the
// result is always word aligned.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic        jump,
  input  logic [31:0] target,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc_s;
  logic [31:0] branch_pc_s;

  assign seq_pc_s    = pc + PC_INCR;
  assign branch_pc_s = seq_pc_s + offset;

  // Priority mux: jump, then branch, then fall-through.
  always_comb begin
    next_pc = word_align(seq_pc_s);
    if (jump) begin
      next_pc = word_align(target);
    end else if (branch) begin
      next_pc = word_align(branch_pc_s);
    end else begin
      next_pc = word_align(seq_pc_s);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches the instruction at pc, holds it in
// EXEC until the pipeline releases it, then advances pc. A fetch that is
// not acknowledged within TIMEOUT request cycles parks the FSM in ERR
// until reset. All outputs except pc_h4 come straight from flops.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        stall,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [3:0]  pc_h4,
  output logic        instr_valid,
  output logic        redirect,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  pc_state_e   state_r;
  logic [31:0] pc_r;
  logic [CW-1:0] wait_r;
  logic        imem_req_r;
  logic        instr_valid_r;
  logic        redirect_r;
  logic        err_r;
  logic [31:0] next_pc_s;

  next_pc_calc u_next_pc_calc (
    .pc      (pc_r),
    .branch  (branch),
    .offset  (offset),
    .jump    (jump),
    .target  (target),
    .next_pc (next_pc_s)
  );

  // FSM, pc register and registered outputs. imem_req_r doubles as the
  // "request is live" qualifier: the FETCH cycle straight out of reset only
  // raises the request, so an ack left over from before reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      wait_r        <= {CW{1'b0}};
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
      redirect_r    <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      redirect_r <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (!imem_req_r) begin
            imem_req_r <= 1'b1;
          end else if (imem_ack) begin
            state_r       <= ST_EXEC;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b1;
          end else if (wait_r == CW'(TIMEOUT - 1)) begin
            state_r    <= ST_ERR;
            imem_req_r <= 1'b0;
            err_r      <= 1'b1;
          end else begin
            wait_r <= wait_r + CW'(1);
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc_r          <= next_pc_s;
            state_r       <= ST_FETCH;
            wait_r        <= {CW{1'b0}};
            imem_req_r    <= 1'b1;
            instr_valid_r <= 1'b0;
            redirect_r    <= jump | branch;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_ERR: begin
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
          err_r         <= 1'b1;
        end
        default: begin
          state_r       <= ST_ERR;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
          err_r         <= 1'b1;
        end
      endcase
    end
  end

  assign pc          = pc_r;
  assign imem_addr   = pc_r;
  assign imem_req    = imem_req_r;
  assign instr_valid = instr_valid_r;
  assign redirect    = redirect_r;
  assign err         = err_r;
  // pc+4 carries into bit 28 only when pc[27:2] is all ones.
  assign pc_h4       = pc_r[31:28] + {3'b000, &pc_r[27:2]};

endmodule
